// File: rtl/eq2_cmp_pkg.sv
// Shared definitions for the eq2_cmp comparator: cell geometry and the result flag bundle.
package eq2_cmp_pkg;

  localparam int CELL_W = 2;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } cmp_flags_t;

  // Number of 2-bit cells needed to cover an operand of width w.
  function automatic int num_cells(input int w);
    return (w + CELL_W - 1) / CELL_W;
  endfunction

endpackage

// File: rtl/eq2_cmp_gt2_cell.sv
// Purely combinational 2-bit unsigned compare cell producing greater-than and equal.
module gt2_cell (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic       gt,
  output logic       eq
);

  logic eq_hi;
  logic eq_lo;

  assign eq_hi = x[1] ~^ y[1];
  assign eq_lo = x[0] ~^ y[0];

  assign gt = (x[1] & ~y[1]) | (eq_hi & x[0] & ~y[0]);
  assign eq = eq_hi & eq_lo;

endmodule

// File: rtl/eq2_cmp.sv
// Registered unsigned magnitude comparator built from cascaded 2-bit cells.
// One-cycle latency, one compare per cycle; flags hold while in_valid is low.
module eq2_cmp
  import eq2_cmp_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             a_lt_b
);

  localparam int NC = num_cells(WIDTH);
  localparam int EW = NC * CELL_W;

  logic [EW-1:0] a_ext;
  logic [EW-1:0] b_ext;
  logic [NC-1:0] cell_gt;
  logic [NC-1:0] cell_eq;
  logic [NC:0]   gt_chain;
  logic [NC:0]   eq_chain;
  cmp_flags_t    flags_d;
  cmp_flags_t    flags_q;
  logic          valid_q;

  // Odd widths leave the top bit of the MS cell at zero on both sides.
  assign a_ext = EW'(a);
  assign b_ext = EW'(b);

  assign gt_chain[0] = 1'b0;
  assign eq_chain[0] = 1'b1;

  // The chain runs from the LS cell upward so that each more significant
  // cell overrides the decision of everything below it unless it is equal.
  for (genvar i = 0; i < NC; i++) begin : g_cell
    gt2_cell u_cell (
      .x  (a_ext[CELL_W*i +: CELL_W]),
      .y  (b_ext[CELL_W*i +: CELL_W]),
      .gt (cell_gt[i]),
      .eq (cell_eq[i])
    );

    assign gt_chain[i+1] = cell_gt[i] | (cell_eq[i] & gt_chain[i]);
    assign eq_chain[i+1] = cell_eq[i] & eq_chain[i];
  end

  always_comb begin
    flags_d    = '0;
    flags_d.gt = gt_chain[NC];
    flags_d.eq = eq_chain[NC];
    flags_d.lt = ~gt_chain[NC] & ~eq_chain[NC];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      flags_q <= '0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        flags_q <= flags_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign a_gt_b    = flags_q.gt;
  assign a_eq_b    = flags_q.eq;
  assign a_lt_b    = flags_q.lt;

endmodule

// File: tb/tb_eq2_cmp.sv
// Self-checking bench for eq2_cmp: WIDTH=2 and WIDTH=5 instances against a behavioural model.
module tb_eq2_cmp;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [1:0] a2, b2;
  logic [4:0] a5, b5;

  logic vld2, gt2, eq2, lt2;
  logic vld5, gt5, eq5, lt5;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;

  // Behavioural model state: what each output must show after the last edge.
  logic m_vld = 0;
  logic m_gt2 = 0, m_eq2 = 0, m_lt2 = 0;
  logic m_gt5 = 0, m_eq5 = 0, m_lt5 = 0;

  eq2_cmp #(.WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a(a2), .b(b2),
    .out_valid(vld2), .a_gt_b(gt2), .a_eq_b(eq2), .a_lt_b(lt2)
  );

  eq2_cmp #(.WIDTH(5)) dut5 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a(a5), .b(b5),
    .out_valid(vld5), .a_gt_b(gt5), .a_eq_b(eq5), .a_lt_b(lt5)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_vld = 0;
      {m_gt2, m_eq2, m_lt2} = 3'b000;
      {m_gt5, m_eq5, m_lt5} = 3'b000;
    end else begin
      m_vld = in_valid;
      if (in_valid) begin
        m_gt2 = (int'(a2) > int'(b2));
        m_eq2 = (int'(a2) == int'(b2));
        m_lt2 = (int'(a2) < int'(b2));
        m_gt5 = (int'(a5) > int'(b5));
        m_eq5 = (int'(a5) == int'(b5));
        m_lt5 = (int'(a5) < int'(b5));
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_vld2", vld2, m_vld);
      chk("model_gt2",  gt2,  m_gt2);
      chk("model_eq2",  eq2,  m_eq2);
      chk("model_lt2",  lt2,  m_lt2);
      chk("model_vld5", vld5, m_vld);
      chk("model_gt5",  gt5,  m_gt5);
      chk("model_eq5",  eq5,  m_eq5);
      chk("model_lt5",  lt5,  m_lt5);
    end
  end

  task automatic drive(input logic r, input logic v, input logic [1:0] x, input logic [1:0] y,
                       input logic [4:0] p, input logic [4:0] q);
    @(negedge clk);
    reset    = r;
    in_valid = v;
    a2 = x; b2 = y;
    a5 = p; b5 = q;
  endtask

  logic [1:0] ta [7] = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
  logic [1:0] tb [7] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b11, 2'b01};
  logic       tg [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic       te [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [4:0] wa [3] = '{5'h10, 5'h0F, 5'h1F};
  logic [4:0] wb [3] = '{5'h0F, 5'h10, 5'h1F};
  logic [2:0] wf [3] = '{3'b100, 3'b001, 3'b010};

  initial begin
    reset = 1; in_valid = 1;
    a2 = 2'b11; b2 = 2'b00;
    a5 = 5'h1F; b5 = 5'h00;
    @(posedge clk);
    chk_en = 1;

    // Reset held with a valid pair on the inputs.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_vld", vld2, 1'b0);
      chk("rst_gt",  gt2,  1'b0);
      chk("rst_eq",  eq2,  1'b0);
      chk("rst_lt",  lt2,  1'b0);
    end
    reset = 0;

    // Directed WIDTH=2 sequence with hand-computed flags.
    for (int k = 0; k < 7; k++) begin
      drive(0, 1, ta[k], tb[k], 5'($urandom), 5'($urandom));
      if (k > 0) begin
        chk("dir_vld", vld2, 1'b1);
        chk("dir_gt",  gt2,  tg[k-1]);
        chk("dir_eq",  eq2,  te[k-1]);
      end
    end
    drive(0, 0, 2'b00, 2'b00, 5'h00, 5'h00);
    chk("dir_gt_last", gt2, tg[6]);
    chk("dir_eq_last", eq2, te[6]);

    // Exhaustive WIDTH=2, back to back; the model checker covers each result.
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 2'(i >> 2), 2'(i), 5'($urandom), 5'($urandom));
      if (i > 0) chk("exh_nobubble", vld2, 1'b1);
    end

    // Hold behaviour when in_valid drops.
    drive(0, 1, 2'b11, 2'b01, 5'h00, 5'h00);
    drive(0, 0, 2'b00, 2'b11, 5'h00, 5'h00);
    chk("hold_vld0", vld2, 1'b1);
    chk("hold_gt0",  gt2,  1'b1);
    drive(0, 0, 2'b00, 2'b11, 5'h00, 5'h00);
    chk("hold_vld1", vld2, 1'b0);
    chk("hold_gt1",  gt2,  1'b1);
    drive(0, 0, 2'b00, 2'b11, 5'h00, 5'h00);
    chk("hold_vld2", vld2, 1'b0);
    chk("hold_gt2",  gt2,  1'b1);

    // Single-cycle reset pulse discards the pair presented with it.
    drive(1, 1, 2'b10, 2'b01, 5'h00, 5'h00);
    drive(0, 1, 2'b01, 2'b00, 5'h00, 5'h00);
    chk("pulse_vld", vld2, 1'b0);
    chk("pulse_gt",  gt2,  1'b0);
    drive(0, 0, 2'b00, 2'b00, 5'h00, 5'h00);
    chk("post_vld", vld2, 1'b1);
    chk("post_gt",  gt2,  1'b1);

    // WIDTH=5 cascade and odd-width MS cell.
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 2'b00, 2'b00, wa[k], wb[k]);
      if (k > 0) begin
        chk("w5_gt", gt5, wf[k-1][2]);
        chk("w5_eq", eq5, wf[k-1][1]);
        chk("w5_lt", lt5, wf[k-1][0]);
      end
    end
    drive(0, 0, 2'b00, 2'b00, 5'h00, 5'h00);
    chk("w5_gt", gt5, wf[2][2]);
    chk("w5_eq", eq5, wf[2][1]);
    chk("w5_lt", lt5, wf[2][0]);

    // Randomized traffic with occasional resets and bubbles.
    for (int i = 0; i < 500; i++) begin
      drive(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
            2'($urandom), 2'($urandom), 5'($urandom), 5'($urandom));
    end
    drive(0, 0, 2'b00, 2'b00, 5'h00, 5'h00);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
